unary_add_multi: RTL and testbench

Parametrised successor to the fixed 2-input, 15-length serial unary adder.
- Accumulate phase: counts the 1s arriving on N_IN parallel unary bitstream lanes into a saturating count.
- Emit phase: replays the count as a thermometer-coded unary stream of exactly STREAM_LEN bits on dout.
- Adds over the earlier block: lane-count generalisation, a sticky overflow flag, a synchronous clear, busy/done handshake, and freeze-on-en-low.
- Sits between unary bitstream producers and downstream unary consumers in the stochastic/unary datapath.

---
 rtl/unary_add_pkg.sv | 18 +
 rtl/unary_popcount.sv | 22 ++
 rtl/unary_add_multi.sv | 139 +++++++++++++
 tb/tb_unary_add_multi.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/unary_add_pkg.sv
// Shared types and sizing helpers for the multi-lane serial unary adder.
package unary_add_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Emit position counter width; a one-bit stream still needs a one-bit counter.
  function automatic int pos_width(input int stream_len);
    return (stream_len <= 1) ? 1 : $clog2(stream_len);
  endfunction

  localparam int POS_W_DEFAULT = pos_width(15);

endpackage

// File: rtl/unary_popcount.sv
// Combinational count of set bits across the parallel unary input lanes.
module unary_popcount #(
  parameter int N_IN = 2,
  parameter int PW   = $clog2(N_IN + 1)
) (
  input  logic [N_IN-1:0] din,
  output logic [PW-1:0]   ones
);

  logic [PW-1:0] ones_s;

  // Sum one bit per lane.
  always_comb begin
    ones_s = {PW{1'b0}};
    for (int i = 0; i < N_IN; i++) begin
      ones_s = ones_s + PW'(din[i]);
    end
  end

  assign ones = ones_s;

endmodule

// File: rtl/unary_add_multi.sv
// Multi-lane saturating unary accumulator that replays its count as a
// thermometer-coded stream of STREAM_LEN bits.
module unary_add_multi
  import unary_add_pkg::*;
#(
  parameter int N_IN       = 2,
  parameter int STREAM_LEN = 15,
  parameter int CNT_W      = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            read_or_write,
  input  logic            clr,
  input  logic [N_IN-1:0] din,
  output logic            dout,
  output logic            C,
  output logic [CNT_W-1:0] count,
  output logic            busy,
  output logic            done
);

  localparam int PW    = $clog2(N_IN + 1);
  localparam int SUM_W = CNT_W + 1;
  localparam int POS_W = pos_width(STREAM_LEN);
  localparam int CMP_W = (POS_W > CNT_W) ? POS_W : CNT_W;

  state_t           state_r;
  logic [POS_W-1:0] pos_r;
  logic [CNT_W-1:0] count_r;
  logic             c_r;
  logic             dout_r;
  logic             busy_r;
  logic             done_r;

  logic [PW-1:0]    pop_s;
  logic [SUM_W-1:0] sum_s;
  logic [CNT_W-1:0] acc_count_s;
  logic             acc_c_s;
  logic             emit_bit_s;
  logic             last_pos_s;

  unary_popcount #(.N_IN(N_IN), .PW(PW)) u_popcount (
    .din  (din),
    .ones (pop_s)
  );

  // Saturating accumulate; overflow is sticky until cleared or emitted.
  always_comb begin
    sum_s = SUM_W'(count_r) + SUM_W'(pop_s);
    if (sum_s > SUM_W'(STREAM_LEN)) begin
      acc_count_s = CNT_W'(STREAM_LEN);
      acc_c_s     = 1'b1;
    end else begin
      acc_count_s = sum_s[CNT_W-1:0];
      acc_c_s     = c_r;
    end
  end

  // Thermometer bit for the current position and end-of-stream detect.
  always_comb begin
    emit_bit_s = (CMP_W'(pos_r) < CMP_W'(count_r));
    last_pos_s = (pos_r == POS_W'(STREAM_LEN - 1));
  end

  // Control FSM with registered outputs; en low freezes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      pos_r   <= {POS_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
      c_r     <= 1'b0;
      dout_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else if (en) begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          dout_r <= 1'b0;
          if (!read_or_write) begin
            state_r <= ACCUM;
            if (clr) begin
              count_r <= {CNT_W{1'b0}};
              c_r     <= 1'b0;
            end else begin
              count_r <= acc_count_s;
              c_r     <= acc_c_s;
            end
          end
        end
        ACCUM: begin
          if (clr) begin
            count_r <= {CNT_W{1'b0}};
            c_r     <= 1'b0;
          end else if (!read_or_write) begin
            count_r <= acc_count_s;
            c_r     <= acc_c_s;
          end
          if (read_or_write) begin
            state_r <= EMIT;
            pos_r   <= {POS_W{1'b0}};
            busy_r  <= 1'b1;
          end
        end
        EMIT: begin
          dout_r <= emit_bit_s;
          pos_r  <= pos_r + POS_W'(1);
          if (last_pos_s) begin
            state_r <= DONE;
          end
        end
        DONE: begin
          // Pulse lands one cycle after the final bit, together with the cleared count.
          done_r  <= 1'b1;
          dout_r  <= 1'b0;
          busy_r  <= 1'b0;
          count_r <= {CNT_W{1'b0}};
          c_r     <= 1'b0;
          pos_r   <= {POS_W{1'b0}};
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          dout_r  <= 1'b0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign dout  = dout_r;
  assign C     = c_r;
  assign count = count_r;
  assign busy  = busy_r;
  assign done  = done_r;

endmodule

// File: tb/tb_unary_add_multi.sv
// Directed self-checking bench for unary_add_multi with N_IN=2, STREAM_LEN=15.
module tb_unary_add_multi;

  localparam int N_IN       = 2;
  localparam int STREAM_LEN = 15;
  localparam int CNT_W      = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             read_or_write;
  logic             clr;
  logic [N_IN-1:0]  din;
  logic             dout;
  logic             C;
  logic [CNT_W-1:0] count;
  logic             busy;
  logic             done;

  int total = 0;
  int bad   = 0;

  unary_add_multi #(.N_IN(N_IN), .STREAM_LEN(STREAM_LEN), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .read_or_write (read_or_write),
    .clr           (clr),
    .din           (din),
    .dout          (dout),
    .C             (C),
    .count         (count),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, got, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, ".dout"},  32'(dout),  32'd0);
    check({tag, ".C"},     32'(C),     32'd0);
    check({tag, ".count"}, 32'(count), 32'd0);
    check({tag, ".busy"},  32'(busy),  32'd0);
    check({tag, ".done"},  32'(done),  32'd0);
  endtask

  // Request emission and check the full stream; optionally drop en after bit freeze_at.
  task automatic emit_run(input string tag, input int exp_ones, input int freeze_at, input int freeze_len);
    int ones;
    read_or_write = 1'b1;
    din = 2'b00;
    tick();
    check({tag, ".busy_start"}, 32'(busy), 32'd1);
    ones = 0;
    for (int i = 1; i <= STREAM_LEN; i++) begin
      tick();
      check({tag, ".bit"}, 32'(dout), (i <= exp_ones) ? 32'd1 : 32'd0);
      check({tag, ".done_early"}, 32'(done), 32'd0);
      ones += int'(dout);
      if (i == freeze_at) begin
        en = 1'b0;
        for (int j = 0; j < freeze_len; j++) begin
          tick();
          check({tag, ".frozen_dout"}, 32'(dout), (i <= exp_ones) ? 32'd1 : 32'd0);
          check({tag, ".frozen_busy"}, 32'(busy), 32'd1);
        end
        en = 1'b1;
      end
    end
    tick();
    check({tag, ".done"},  32'(done),  32'd1);
    check({tag, ".dout0"}, 32'(dout),  32'd0);
    check({tag, ".busy0"}, 32'(busy),  32'd0);
    check({tag, ".count0"}, 32'(count), 32'd0);
    check({tag, ".C0"},    32'(C),     32'd0);
    check({tag, ".ones"},  32'(ones),  32'(exp_ones));
    // read_or_write still high: one-cycle pulse and no retrigger
    tick();
    check({tag, ".done_off"}, 32'(done), 32'd0);
    check({tag, ".no_retrig"}, 32'(busy), 32'd0);
    tick();
    check({tag, ".idle_dout"}, 32'(dout), 32'd0);
    check({tag, ".idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b1;
    read_or_write = 1'b0;
    clr = 1'b0;
    din = 2'b00;

    // Reset held while inputs wiggle
    for (int i = 0; i < 4; i++) begin
      din = 2'(i);
      en  = i[0];
      tick();
      check_idle_zero("rst");
    end
    en = 1'b1;
    din = 2'b00;
    rst_n = 1'b1;
    tick();

    // Basic add: 3x(11) + 2x(01) = 8
    read_or_write = 1'b0;
    din = 2'b11;
    for (int i = 0; i < 3; i++) tick();
    check("add.count6", 32'(count), 32'd6);
    din = 2'b01;
    for (int i = 0; i < 2; i++) tick();
    check("add.count8", 32'(count), 32'd8);
    check("add.C", 32'(C), 32'd0);
    emit_run("add", 8, 0, 0);

    // Saturation: 19x(11)
    read_or_write = 1'b0;
    din = 2'b11;
    for (int c = 1; c <= 19; c++) begin
      tick();
      if (c == 7) begin
        check("sat.count7", 32'(count), 32'd14);
        check("sat.C7", 32'(C), 32'd0);
      end
      if (c == 8) begin
        check("sat.count8", 32'(count), 32'd15);
        check("sat.C8", 32'(C), 32'd1);
      end
    end
    check("sat.count19", 32'(count), 32'd15);
    check("sat.C19", 32'(C), 32'd1);
    emit_run("sat", 15, 0, 0);

    // en freeze mid-emission
    read_or_write = 1'b0;
    din = 2'b11;
    for (int i = 0; i < 4; i++) tick();
    check("frz.count", 32'(count), 32'd8);
    emit_run("frz", 8, 4, 3);

    // Clear priority over same-cycle din
    read_or_write = 1'b0;
    din = 2'b11;
    for (int i = 0; i < 3; i++) tick();
    check("clr.count6", 32'(count), 32'd6);
    clr = 1'b1;
    tick();
    check("clr.count0", 32'(count), 32'd0);
    check("clr.C0", 32'(C), 32'd0);
    clr = 1'b0;
    din = 2'b10;
    tick();
    check("clr.count1", 32'(count), 32'd1);
    din = 2'b11;
    for (int i = 0; i < 9; i++) tick();
    check("clr.sat_count", 32'(count), 32'd15);
    check("clr.sat_C", 32'(C), 32'd1);
    clr = 1'b1;
    tick();
    check("clr.sticky_C", 32'(C), 32'd0);
    check("clr.sticky_count", 32'(count), 32'd0);
    clr = 1'b0;

    // Reset mid-emission at pos=5
    din = 2'b11;
    for (int i = 0; i < 5; i++) tick();
    check("rme.count", 32'(count), 32'd10);
    read_or_write = 1'b1;
    din = 2'b00;
    tick();
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("rme.bit", 32'(dout), 32'd1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_zero("rme.async");
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle_zero("rme.after");
    end

    // Zero count emits all zeros but still completes
    read_or_write = 1'b0;
    din = 2'b00;
    tick();
    check("zero.count", 32'(count), 32'd0);
    emit_run("zero", 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
